// File: rtl/dlfloat16_issue_ctrl.sv
// Single-issue sequencer for the DLFloat16 FPU: latches one request, launches it,
// waits the class latency, captures result/flags and holds them on a valid/ready port.
module dlfloat16_issue_ctrl #(
    parameter int unsigned LAT_ADDSUB = 2,
    parameter int unsigned LAT_MUL    = 2,
    parameter int unsigned LAT_DIV    = 8,
    parameter int unsigned LAT_SQRT   = 8,
    parameter int unsigned LAT_MAC    = 3,
    parameter int unsigned LAT_MISC   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    input  logic [31:0] in_op3,
    output logic [31:0] fpu_instr,
    output logic [31:0] fpu_op1,
    output logic [31:0] fpu_op2,
    output logic [31:0] fpu_op3,
    output logic        fpu_start,
    input  logic [31:0] fpu_result,
    input  logic [4:0]  fpu_excep,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_excep,
    output logic [4:0]  fflags,
    input  logic        fflags_clr,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        CAPT,
        DONE
    } state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [3:0] cls_lat;
    logic       cls_legal;
    logic       accept;
    logic       retire;

    always_comb begin
        cls_lat   = 4'd1;
        cls_legal = 1'b1;
        case (in_instr[3:0])
            4'd0, 4'd1:               cls_lat = 4'(LAT_ADDSUB);
            4'd2:                     cls_lat = 4'(LAT_MUL);
            4'd3:                     cls_lat = 4'(LAT_DIV);
            4'd4:                     cls_lat = 4'(LAT_SQRT);
            4'd5, 4'd6:               cls_lat = 4'(LAT_MAC);
            4'd7, 4'd8, 4'd9, 4'd10:  cls_lat = 4'(LAT_MISC);
            default:                  cls_legal = 1'b0;
        endcase
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign fpu_start = (state == START);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;

    // Counter holds the cycles still owed before the FPU result is valid;
    // CAPT is entered on the cycle the count would reach one.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (cls_legal) begin
                        state_nx = START;
                        cnt_nx   = cls_lat;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            START: begin
                if (cnt == 4'd1) begin
                    state_nx = CAPT;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = cnt - 4'd1;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_nx = CAPT;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            CAPT: state_nx = DONE;
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_instr  <= '0;
            fpu_op1    <= '0;
            fpu_op2    <= '0;
            fpu_op3    <= '0;
            out_result <= '0;
            out_excep  <= '0;
            fflags     <= '0;
        end else begin
            if (accept) begin
                fpu_instr <= in_instr;
                fpu_op1   <= in_op1;
                fpu_op2   <= in_op2;
                fpu_op3   <= in_op3;
            end
            // Illegal classes retire immediately as an invalid-operation result.
            if (accept && !cls_legal) begin
                out_result <= '0;
                out_excep  <= 5'b10000;
            end else if (state == CAPT) begin
                out_result <= fpu_result;
                out_excep  <= fpu_excep;
            end
            if (retire) begin
                fflags <= (fflags_clr ? 5'b00000 : fflags) | out_excep;
            end else if (fflags_clr) begin
                fflags <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dlfloat16_issue_ctrl.sv
// Self-checking bench for dlfloat16_issue_ctrl: vector table, scoreboard queue,
// cycle-accurate monitor and a fixed-latency FPU stand-in.
module tb_dlfloat16_issue_ctrl;

    localparam int LA_ADDSUB = 2;
    localparam int LA_MUL    = 2;
    localparam int LA_DIV    = 8;
    localparam int LA_SQRT   = 8;
    localparam int LA_MAC    = 3;
    localparam int LA_MISC   = 1;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr, in_op1, in_op2, in_op3;
    logic [31:0] fpu_instr, fpu_op1, fpu_op2, fpu_op3;
    logic        fpu_start;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_excep;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_excep;
    logic [4:0]  fflags;
    logic        fflags_clr;
    logic        busy;

    dlfloat16_issue_ctrl #(
        .LAT_ADDSUB(LA_ADDSUB),
        .LAT_MUL   (LA_MUL),
        .LAT_DIV   (LA_DIV),
        .LAT_SQRT  (LA_SQRT),
        .LAT_MAC   (LA_MAC),
        .LAT_MISC  (LA_MISC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_op1    (in_op1),
        .in_op2    (in_op2),
        .in_op3    (in_op3),
        .fpu_instr (fpu_instr),
        .fpu_op1   (fpu_op1),
        .fpu_op2   (fpu_op2),
        .fpu_op3   (fpu_op3),
        .fpu_start (fpu_start),
        .fpu_result(fpu_result),
        .fpu_excep (fpu_excep),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_excep (out_excep),
        .fflags    (fflags),
        .fflags_clr(fflags_clr),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] op3;
        logic [31:0] res;
        logic [4:0]  ex;
        int          lat;
    } exp_t;

    exp_t   sb[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc = 0;
    bit     mon_en = 0;
    bit     inflight = 0;
    int     n_acc = 0;
    longint start_cyc = -1;
    longint done_cyc = 0;
    logic [4:0] exp_ff = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input logic [3:0] c);
        case (c)
            4'd0, 4'd1:              return LA_ADDSUB;
            4'd2:                    return LA_MUL;
            4'd3:                    return LA_DIV;
            4'd4:                    return LA_SQRT;
            4'd5, 4'd6:              return LA_MAC;
            4'd7, 4'd8, 4'd9, 4'd10: return LA_MISC;
            default:                 return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FPU stand-in: result = op1+op2, flags = op3[4:0], valid only in cycle start+LAT.
    int          rem = 0;
    bit          fpu_hit;
    logic [31:0] p_res;
    logic [4:0]  p_ex;
    always @(negedge clk) begin
        fpu_hit = 1'b0;
        if (fpu_start) begin
            rem   = lat_of(fpu_instr[3:0]);
            p_res = fpu_op1 + fpu_op2;
            p_ex  = fpu_op3[4:0];
        end else if (rem != 0) begin
            fpu_hit = (rem == 1);
            rem--;
        end
        if (fpu_hit) begin
            fpu_result = p_res;
            fpu_excep  = p_ex;
        end else begin
            fpu_result = $urandom;
            fpu_excep  = 5'($urandom);
        end
    end

    // Monitor: per-cycle protocol checks against the bench's own timing model.
    bit ready_exp, ov_exp, st_exp;
    always @(negedge clk) begin
        if (mon_en) begin
            ready_exp = !rst && !inflight;
            ov_exp    = inflight && (cyc >= done_cyc);
            st_exp    = inflight && (cyc == start_cyc);
            check("in_ready", 32'(in_ready), 32'(ready_exp));
            check("out_valid", 32'(out_valid), 32'(ov_exp));
            check("fpu_start", 32'(fpu_start), 32'(st_exp));
            check("busy", 32'(busy), 32'(inflight));
            check("fflags", 32'(fflags), 32'(exp_ff));
            if (ov_exp && sb.size() > 0) begin
                check("out_result", out_result, sb[0].res);
                check("out_excep", 32'(out_excep), 32'(sb[0].ex));
            end
            if (st_exp && sb.size() > 0) begin
                check("fpu_instr", fpu_instr, sb[0].instr);
                check("fpu_op1", fpu_op1, sb[0].op1);
                check("fpu_op2", fpu_op2, sb[0].op2);
                check("fpu_op3", fpu_op3, sb[0].op3);
            end
            if (rst) begin
                if (inflight && sb.size() > 0) sb.delete(0);
                inflight = 0;
                exp_ff   = '0;
            end else begin
                if (ov_exp && out_ready) begin
                    if (sb.size() > 0) begin
                        exp_ff = (fflags_clr ? 5'b00000 : exp_ff) | sb[0].ex;
                        sb.delete(0);
                    end
                    inflight = 0;
                end else if (fflags_clr) begin
                    exp_ff = '0;
                end
                if (ready_exp && in_valid && sb.size() > 0) begin
                    inflight = 1;
                    n_acc++;
                    if (sb[0].lat != 0) begin
                        start_cyc = cyc + 1;
                        done_cyc  = cyc + sb[0].lat + 2;
                    end else begin
                        start_cyc = -1;
                        done_cyc  = cyc + 1;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] instr, input logic [31:0] op1, input logic [31:0] op2,
                         input logic [31:0] op3, input logic [31:0] res, input logic [4:0] ex,
                         input int lat, input bit keep);
        exp_t e;
        int   base;
        e.instr = instr; e.op1 = op1; e.op2 = op2; e.op3 = op3;
        e.res = res; e.ex = ex; e.lat = lat;
        sb.push_back(e);
        in_instr = instr; in_op1 = op1; in_op2 = op2; in_op3 = op3;
        in_valid = 1'b1;
        base = n_acc;
        for (int k = 0; k < 200 && n_acc == base; k++) @(posedge clk);
        #1;
        if (n_acc == base) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept of instr %h", instr);
            sb.delete();
        end
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((inflight || sb.size() != 0) && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (inflight || sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got busy expected idle within %0d cycles", budget);
            sb.delete();
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] op3;
        logic [31:0] res;
        logic [4:0]  ex;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h0000_0000, 32'h0000_4000, 32'h0000_0200, 32'h0000_0000, 32'h0000_4200, 5'b00000, 2};
        vecs[1]  = '{32'h1234_5011, 32'h0000_1000, 32'h0000_0234, 32'h0000_0001, 32'h0000_1234, 5'b00001, 2};
        vecs[2]  = '{32'h0000_0022, 32'h0000_0010, 32'h0000_0020, 32'hFFFF_FFE8, 32'h0000_0030, 5'b01000, 2};
        vecs[3]  = '{32'hABCD_0003, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 32'h0000_0003, 5'b00000, 8};
        vecs[4]  = '{32'h0000_0074, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 5'b00010, 8};
        vecs[5]  = '{32'h0000_0005, 32'h0000_0100, 32'h0000_0200, 32'h0000_0004, 32'h0000_0300, 5'b00100, 3};
        vecs[6]  = '{32'h0000_0006, 32'h0000_0007, 32'h0000_0008, 32'h0000_0000, 32'h0000_000F, 5'b00000, 3};
        vecs[7]  = '{32'h0000_0007, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 32'h0000_000A, 5'b00001, 1};
        vecs[8]  = '{32'h0000_0008, 32'h1000_0000, 32'h0000_0001, 32'h0000_0000, 32'h1000_0001, 5'b00000, 1};
        vecs[9]  = '{32'h0000_0009, 32'h0000_00F0, 32'h0000_000F, 32'h0000_0010, 32'h0000_00FF, 5'b10000, 1};
        vecs[10] = '{32'h0000_000A, 32'h8000_0000, 32'h8000_0000, 32'h0000_0003, 32'h0000_0000, 5'b00011, 1};
        vecs[11] = '{32'h0000_000B, 32'h0000_0005, 32'h0000_0006, 32'h0000_001F, 32'h0000_0000, 5'b10000, 0};
        vecs[12] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 5'b10000, 0};
        vecs[13] = '{32'h0000_000C, 32'h0000_0009, 32'h0000_0009, 32'h0000_0001, 32'h0000_0000, 5'b10000, 0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; fflags_clr = 1'b0;
        in_instr = '0; in_op1 = '0; in_op2 = '0; in_op3 = '0;
        fpu_result = '0; fpu_excep = '0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("rst_fpu_instr", fpu_instr, 32'h0);
        check("rst_fpu_op1", fpu_op1, 32'h0);
        check("rst_fpu_op3", fpu_op3, 32'h0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_excep", 32'(out_excep), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table: every class once, including illegal encodings.
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].instr, vecs[i].op1, vecs[i].op2, vecs[i].op3,
                  vecs[i].res, vecs[i].ex, vecs[i].lat, 1'b0);
        end
        wait_idle(50);
        check("illegal_sets_fflags4", 32'(fflags[4]), 32'h1);

        // Sticky flags, then clear coinciding with a handshake.
        fflags_clr = 1'b1;
        @(posedge clk);
        #1;
        fflags_clr = 1'b0;
        check("fflags_cleared", 32'(fflags), 32'h0);
        issue(32'h0000_0002, 32'h3, 32'h4, 32'h1, 32'h7, 5'b00001, LA_MUL, 1'b0);
        wait_idle(50);
        issue(32'h0000_0003, 32'h10, 32'h20, 32'h8, 32'h30, 5'b01000, LA_DIV, 1'b0);
        wait_idle(50);
        check("fflags_sticky", 32'(fflags), 32'h09);
        out_ready = 1'b0;
        issue(32'h0000_0000, 32'h1, 32'h1, 32'h4, 32'h2, 5'b00100, LA_ADDSUB, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        out_ready  = 1'b1;
        fflags_clr = 1'b1;
        @(posedge clk);
        #1;
        fflags_clr = 1'b0;
        check("fflags_clr_with_retire", 32'(fflags), 32'h04);
        wait_idle(20);

        // Backpressure on a div: out_valid at T10, held ten more cycles.
        out_ready = 1'b0;
        issue(32'h0000_0003, 32'h0000_1111, 32'h0000_2222, 32'h0000_0002, 32'h0000_3333, 5'b00010, LA_DIV, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        check("bp_out_result_held", out_result, 32'h0000_3333);
        out_ready = 1'b1;
        wait_idle(20);

        // Reset in the middle of a div's WAIT phase.
        issue(32'h0000_0003, 32'h0000_0AAA, 32'h0000_0555, 32'h0000_001F, 32'h0000_0FFF, 5'b11111, LA_DIV, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("rst_mid_out_result", out_result, 32'h0);
        check("rst_mid_out_excep", 32'(out_excep), 32'h0);
        check("rst_mid_fflags", 32'(fflags), 32'h0);

        // Back-to-back random legal classes with in_valid and out_ready held high.
        for (int i = 0; i < 20; i++) begin
            logic [31:0] r, a, b, c;
            logic [3:0]  cls;
            cls = 4'($urandom_range(0, 10));
            r = $urandom;
            r[3:0] = cls;
            a = $urandom; b = $urandom; c = $urandom;
            issue(r, a, b, c, a + b, c[4:0], lat_of(cls), 1'b1);
        end
        in_valid = 1'b0;
        wait_idle(50);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
